fft_bitrev_reorder: RTL and testbench

//  Output-side reader of the FFT pipeline. Accepts complex samples in bit-reversed

---
 rtl/fft_bitrev_reorder.sv | 62 ++++++
 tb/tb_fft_bitrev_reorder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong buffer that takes bit-reversed FFT frames and emits them in natural order
module fft_bitrev_reorder #(
   parameter int WIDTH = 14,
   parameter int LOG2N = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_real,
   input  logic [WIDTH-1:0] in_imag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_real,
   output logic [WIDTH-1:0] out_imag,
   output logic             out_last
);
   localparam int N = 1 << LOG2N;
   logic [2*WIDTH-1:0] mem [2][N];
   logic [1:0] full;
   logic wr_sel, rd_sel, wr_en, load_en;
   logic [LOG2N-1:0] wr_cnt, rd_cnt, wr_addr;
   assign wr_addr = {<<{wr_cnt}};
   assign in_ready = !full[wr_sel];
   assign wr_en = in_valid && in_ready;
   assign load_en = full[rd_sel] && (!out_valid || out_ready);
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_sel][wr_addr] <= {in_real, in_imag};
   end
   // counters wrap to 0 on their own since N is a power of two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full      <= '0;
         wr_sel    <= 1'b0;
         rd_sel    <= 1'b0;
         wr_cnt    <= '0;
         rd_cnt    <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_real  <= '0;
         out_imag  <= '0;
      end else begin
         if (wr_en) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (&wr_cnt) begin
               full[wr_sel] <= 1'b1;
               wr_sel       <= !wr_sel;
            end
         end
         if (load_en) begin
            {out_real, out_imag} <= mem[rd_sel][rd_cnt];
            out_valid <= 1'b1;
            out_last  <= &rd_cnt;
            rd_cnt    <= rd_cnt + 1'b1;
            if (&rd_cnt) begin
               full[rd_sel] <= 1'b0;
               rd_sel       <= !rd_sel;
            end
         end else if (out_ready) out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb_fft_bitrev_reorder: table and scoreboard bench for the bit-reverse reorder buffer
module tb_fft_bitrev_reorder;
   localparam int W = 14;
   typedef struct packed {
      logic [7:0][W-1:0] re, im, exp_re, exp_im;
      logic              gaps;
   } vec_t;
   typedef struct packed {
      logic [W-1:0] re, im;
      logic         last;
   } exp_t;
   logic clk = 1'b0;
   logic rst, in_valid, in_ready, out_valid, out_ready, out_last;
   logic [W-1:0] in_real, in_imag, out_real, out_imag;
   exp_t sb[$];
   exp_t mon_e;
   vec_t vecs[3];
   int passed = 0, total = 0, cyc = 0, hs_n = 0, first_hs = 0, last_hs = 0, drops = 0;
   bit stream_on = 1'b0;

   fft_bitrev_reorder #(.WIDTH(W), .LOG2N(3)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
      .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
      .out_last(out_last)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act == req) passed++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
   endtask

   always @(negedge clk) begin
      if (stream_on && !in_ready) drops++;
      if (!rst && out_valid && out_ready) begin
         if (hs_n == 0) first_hs = cyc;
         last_hs = cyc;
         hs_n++;
         if (sb.size() == 0) begin
            total++;
            $display("FAIL sb_underflow: unexpected output real=0x%0h imag=0x%0h, expected no output", out_real, out_imag);
         end else begin
            mon_e = sb.pop_front();
            check("out_real", int'(out_real), int'(mon_e.re));
            check("out_imag", int'(out_imag), int'(mon_e.im));
            check("out_last", int'(out_last), int'(mon_e.last));
         end
      end
   end

   function automatic vec_t mk_rand();
      vec_t v;
      int j;
      v = '0;
      for (int i = 0; i < 8; i++) begin
         v.re[i] = W'($urandom);
         v.im[i] = W'($urandom);
      end
      for (int k = 0; k < 8; k++) begin
         j = ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
         v.exp_re[k] = v.re[j];
         v.exp_im[k] = v.im[j];
      end
      return v;
   endfunction

   task automatic expect_vec(input vec_t v);
      for (int k = 0; k < 8; k++) sb.push_back(exp_t'({v.exp_re[k], v.exp_im[k], k == 7}));
   endtask

   task automatic send(input logic [W-1:0] re, input logic [W-1:0] im);
      int t;
      bit ok;
      t = 0;
      in_valid = 1'b1;
      in_real = re;
      in_imag = im;
      do begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         t++;
      end while (!ok && t < 200);
      if (!ok) begin
         total++;
         $display("FAIL send_timeout: in_ready was 0 for %0d cycles, expected 1", t);
      end
      in_valid = 1'b0;
   endtask

   task automatic drive_vec(input vec_t v);
      for (int j = 0; j < 8; j++) begin
         send(v.re[j], v.im[j]);
         if (v.gaps) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic freeze(input string name, input int n);
      logic [2*W+1:0] snap;
      int bad;
      bad = 0;
      @(negedge clk);
      snap = {out_valid, out_last, out_real, out_imag};
      check({name, "_valid"}, int'(snap[2*W+1]), 1);
      repeat (n) begin
         @(negedge clk);
         if ({out_valid, out_last, out_real, out_imag} !== snap) bad++;
      end
      check(name, bad, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 300) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("drain", sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      vec_t s[4];
      vec_t r;
      int n;
      int e2[8] = '{0, 40, 20, 60, 10, 50, 30, 70};
      int xr[8] = '{5, -8192, 7, -8192, 9, 11, -8192, 13};
      int xi[8] = '{-5, 8191, -7, 8191, -9, -11, 8191, -13};
      int er[8] = '{5, 9, 7, -8192, -8192, 11, -8192, 13};
      int ei[8] = '{-5, -9, -7, 8191, 8191, -11, 8191, -13};
      rst = 1'b1;
      in_valid = 1'b0;
      in_real = '0;
      in_imag = '0;
      out_ready = 1'b1;
      for (int j = 0; j < 8; j++) begin
         vecs[0].re[j] = W'(j * 10);
         vecs[0].im[j] = W'(-j * 10);
         vecs[0].exp_re[j] = W'(e2[j]);
         vecs[0].exp_im[j] = W'(-e2[j]);
         vecs[2].re[j] = W'(xr[j]);
         vecs[2].im[j] = W'(xi[j]);
         vecs[2].exp_re[j] = W'(er[j]);
         vecs[2].exp_im[j] = W'(ei[j]);
      end
      vecs[0].gaps = 1'b0;
      vecs[2].gaps = 1'b0;
      vecs[1] = vecs[0];
      vecs[1].gaps = 1'b1;
      for (int f = 0; f < 4; f++) s[f] = mk_rand();

      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", int'(out_valid), 0);
      check("rst_real", int'(out_real), 0);
      check("rst_imag", int'(out_imag), 0);
      check("rst_last", int'(out_last), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst_in_ready", int'(in_ready), 1);

      expect_vec(vecs[0]);
      drive_vec(vecs[0]);
      check("lat_before", int'(out_valid), 0);
      @(posedge clk);
      #1;
      check("lat_first", int'(out_valid), 1);
      n = 0;
      repeat (8) begin
         if (out_valid) n++;
         @(posedge clk);
         #1;
      end
      check("burst_len", n, 8);
      check("idle_after", int'(out_valid), 0);
      drain();

      r = mk_rand();
      expect_vec(r);
      drive_vec(r);
      repeat (3) @(posedge clk);
      #1;
      send(14'h0123, 14'h0456);
      send(14'h0789, 14'h0abc);
      check("pre_rst_valid", int'(out_valid), 1);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", int'(out_valid), 0);
      check("mid_rst_real", int'(out_real), 0);
      check("mid_rst_imag", int'(out_imag), 0);
      check("mid_rst_last", int'(out_last), 0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_in_ready", int'(in_ready), 1);

      expect_vec(vecs[1]);
      drive_vec(vecs[1]);
      drain();

      hs_n = 0;
      drops = 0;
      for (int f = 0; f < 4; f++) expect_vec(s[f]);
      stream_on = 1'b1;
      for (int f = 0; f < 4; f++) drive_vec(s[f]);
      stream_on = 1'b0;
      drain();
      check("stream_in_ready_drops", drops, 0);
      check("stream_outputs", hs_n, 32);
      check("stream_span", last_hs - first_hs, 31);

      for (int f = 0; f < 3; f++) s[f] = mk_rand();
      out_ready = 1'b0;
      for (int f = 0; f < 3; f++) expect_vec(s[f]);
      drive_vec(s[0]);
      drive_vec(s[1]);
      check("both_full_in_ready", int'(in_ready), 0);
      fork
         drive_vec(s[2]);
         begin
            freeze("freeze_full", 5);
            out_ready = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b0;
            freeze("freeze_mid", 5);
            out_ready = 1'b1;
         end
      join
      drain();
      repeat (3) @(posedge clk);
      #1;
      check("no_extra", int'(out_valid), 0);

      expect_vec(vecs[2]);
      drive_vec(vecs[2]);
      drain();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
